risc_v_mike_fetch_ctrl: RTL and testbench

Instruction fetch controller that sequences the combinational-read instruction memory. It owns the fetch PC and drives the word-aligned byte address into instruction memory each cycle. Returned words are buffered, together with their PC, in a small queue that decode drains through a valid/ready handshake. The block also handles redirects (branch/jump/trap), fetch pause, and misaligned or out-of-range fetch faults.

---
 rtl/risc_v_mike_fetch_ctrl.sv | 156 +++++++++++++++
 tb/tb_risc_v_mike_fetch_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/risc_v_mike_fetch_ctrl.sv
// Instruction fetch controller: owns the fetch PC, reads a combinational
// instruction memory, and buffers {instruction, pc} pairs in a small queue
// that decode drains through a valid/ready handshake. Redirects flush the
// queue; misaligned redirect targets and out-of-range fetches raise sticky
// fault flags and park the block in a fault state until a good redirect.
module risc_v_mike_fetch_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned IMEM_DEPTH  = 1024,
  parameter int unsigned QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rd_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  output logic        fault_misaligned,
  output logic        fault_range,
  output logic        busy
);

  localparam int unsigned PtrW = $clog2(QUEUE_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] CountFull = CntW'(QUEUE_DEPTH);
  // One extra bit so IMEM_DEPTH = 2^30 still compares correctly.
  localparam logic [30:0] DepthLimit = 31'(IMEM_DEPTH);
  localparam logic [31:0] Nop = 32'h0000_0013;

  typedef enum logic [1:0] {StIdle, StFetch, StFault} state_e;

  state_e              state_q;
  logic [31:0]         fetch_pc_q;
  logic                fault_mis_q;
  logic                fault_rng_q;
  logic                busy_q;

  logic [31:0]         q_data [QUEUE_DEPTH];
  logic [31:0]         q_pc   [QUEUE_DEPTH];
  logic [PtrW-1:0]     rd_ptr_q;
  logic [PtrW-1:0]     wr_ptr_q;
  logic [CntW-1:0]     count_q;

  logic                pc_out_of_range;
  logic                redir_misaligned;
  logic                redir_out_of_range;
  logic                queue_empty;
  logic                pop;
  logic                push;

  assign imem_addr          = fetch_pc_q;
  assign pc_out_of_range    = {1'b0, fetch_pc_q[31:2]} >= DepthLimit;
  assign redir_misaligned   = redirect_pc[1:0] != 2'b00;
  assign redir_out_of_range = {1'b0, redirect_pc[31:2]} >= DepthLimit;
  assign queue_empty        = count_q == '0;

  // Handshake and push qualification; a pop frees a slot in the same cycle.
  always_comb begin
    instr_valid = !queue_empty && !redirect_valid;
    pop         = instr_valid && instr_ready;
    push        = (state_q == StFetch) && fetch_en && !redirect_valid && !pc_out_of_range &&
                  ((count_q != CountFull) || pop);
    instr_data  = queue_empty ? Nop   : q_data[rd_ptr_q];
    instr_pc    = queue_empty ? 32'h0 : q_pc[rd_ptr_q];
  end

  assign fault_misaligned = fault_mis_q;
  assign fault_range      = fault_rng_q;
  assign busy             = busy_q;

  // Fetch FSM: state, fetch PC, sticky fault flags and registered busy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      fetch_pc_q  <= RESET_PC;
      fault_mis_q <= 1'b0;
      fault_rng_q <= 1'b0;
      busy_q      <= 1'b0;
    end else if (redirect_valid) begin
      fetch_pc_q <= redirect_pc;
      if (redir_misaligned) begin
        fault_mis_q <= 1'b1;
        state_q     <= StFault;
        busy_q      <= 1'b0;
      end else if (redir_out_of_range) begin
        fault_rng_q <= 1'b1;
        state_q     <= StFault;
        busy_q      <= 1'b0;
      end else begin
        fault_mis_q <= 1'b0;
        fault_rng_q <= 1'b0;
        state_q     <= StFetch;
        busy_q      <= 1'b1;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (fetch_en) begin
            state_q <= StFetch;
            busy_q  <= 1'b1;
          end
        end
        StFetch: begin
          if (pc_out_of_range) begin
            fault_rng_q <= 1'b1;
            state_q     <= StFault;
            busy_q      <= 1'b0;
          end else if (push) begin
            fetch_pc_q <= fetch_pc_q + 32'd4;
          end
        end
        StFault: begin
          // Only a good redirect leaves this state.
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Queue pointers and occupancy; a redirect flushes everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (redirect_valid) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop) begin
        count_q <= count_q + CntW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

  // Queue storage; contents are only observed through count, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      q_data[wr_ptr_q] <= imem_rd_data;
      q_pc[wr_ptr_q]   <= fetch_pc_q;
    end
  end

endmodule

// File: tb/tb_risc_v_mike_fetch_ctrl.sv
// Randomized scoreboard bench for the fetch controller. A transaction-level
// model decides, per cycle, which instruction should enter the fetch queue;
// a separate monitor checks the head and retires entries on each handshake.
module tb_risc_v_mike_fetch_ctrl;

  localparam int unsigned Depth   = 16;
  localparam int unsigned QDepth  = 2;
  localparam logic [31:0] ResetPc = 32'h0000_0000;
  localparam logic [31:0] Nop     = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_rd_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        fault_misaligned;
  logic        fault_range;
  logic        busy;

  always #5 clk = ~clk;

  risc_v_mike_fetch_ctrl #(
    .RESET_PC   (ResetPc),
    .IMEM_DEPTH (Depth),
    .QUEUE_DEPTH(QDepth)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .fetch_en        (fetch_en),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_addr       (imem_addr),
    .imem_rd_data    (imem_rd_data),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr_data      (instr_data),
    .instr_pc        (instr_pc),
    .fault_misaligned(fault_misaligned),
    .fault_range     (fault_range),
    .busy            (busy)
  );

  // Memory contents are a fixed function of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h0001_0001) ^ 32'h0000_0037;
  endfunction

  assign imem_rd_data = mem_word(imem_addr);

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] pc;
  } entry_t;

  typedef enum {MIdle, MFetch, MFault} mode_e;

  entry_t      exp_q[$];
  mode_e       mode;
  logic [31:0] m_pc;
  logic        m_fm;
  logic        m_fr;

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    exp_q.delete();
    mode = MIdle;
    m_pc = ResetPc;
    m_fm = 1'b0;
    m_fr = 1'b0;
  endtask

  // Reference behaviour for the coming clock edge, given the current inputs.
  task automatic model_step();
    if (redirect_valid) begin
      exp_q.delete();
      m_pc = redirect_pc;
      if (redirect_pc % 4 != 0) begin
        m_fm = 1'b1;
        mode = MFault;
      end else if (redirect_pc / 4 >= Depth) begin
        m_fr = 1'b1;
        mode = MFault;
      end else begin
        m_fm = 1'b0;
        m_fr = 1'b0;
        mode = MFetch;
      end
    end else if (mode == MIdle) begin
      if (fetch_en) mode = MFetch;
    end else if (mode == MFetch) begin
      if (m_pc / 4 >= Depth) begin
        m_fr = 1'b1;
        mode = MFault;
      end else if (fetch_en && exp_q.size() < QDepth) begin
        exp_q.push_back('{data: mem_word(m_pc), pc: m_pc});
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  function automatic logic [31:0] rand_target();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r < 6) return 32'($urandom_range(0, Depth - 1)) << 2;
    if (r < 8) return (32'($urandom_range(0, Depth - 1)) << 2) | 32'($urandom_range(1, 3));
    if (r < 9) return 32'($urandom_range(Depth, Depth + 4)) << 2;
    return 32'hFFFF_FFFC;
  endfunction

  // Directed opening phases, then random traffic.
  task automatic drive(input int cyc);
    redirect_valid = 1'b0;
    fetch_en       = 1'b1;
    instr_ready    = 1'b1;
    if (cyc >= 12 && cyc <= 16) instr_ready = 1'b0;
    else if (cyc >= 22 && cyc <= 24) instr_ready = 1'b0;
    else if (cyc == 25) begin
      redirect_valid = 1'b1;
      redirect_pc    = 32'h40 >> 1;
    end else if (cyc == 30) begin
      redirect_valid = 1'b1;
      redirect_pc    = 32'h42;
    end else if (cyc == 35) begin
      redirect_valid = 1'b1;
      redirect_pc    = 32'h10;
    end else if (cyc >= 36 && cyc <= 60) begin
      instr_ready = ($urandom_range(0, 3) != 0);
    end else if (cyc == 1488) begin
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0;
    end else if (cyc >= 1489 && cyc <= 1499) begin
      instr_ready = 1'b0;
    end else if (cyc > 60) begin
      fetch_en       = ($urandom_range(0, 99) < 85);
      instr_ready    = ($urandom_range(0, 99) < 70);
      redirect_valid = ($urandom_range(0, 99) < 8);
      redirect_pc    = rand_target();
    end
  endtask

  // Asynchronous reset in mid-cycle, away from any clock edge.
  task automatic do_reset();
    #1;
    rst            = 1'b0;
    redirect_valid = 1'b0;
    fetch_en       = 1'b0;
    #1;
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_addr", imem_addr, ResetPc);
    chk("rst_busy", busy, 1'b0);
    chk("rst_fault_mis", fault_misaligned, 1'b0);
    chk("rst_fault_rng", fault_range, 1'b0);
    chk("rst_data", instr_data, Nop);
    chk("rst_pc", instr_pc, 32'h0);
    model_reset();
    repeat (2) @(negedge clk);
    #3 rst = 1'b1;
  endtask

  // Monitor: head contents and valid each cycle, retire entries on handshake.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      chk("instr_valid", instr_valid, (exp_q.size() != 0) && !redirect_valid);
      if (exp_q.size() == 0) begin
        chk("empty_data", instr_data, Nop);
        chk("empty_pc", instr_pc, 32'h0);
      end else if (instr_valid) begin
        chk("head_data", instr_data, exp_q[0].data);
        chk("head_pc", instr_pc, exp_q[0].pc);
        if (instr_ready) void'(exp_q.pop_front());
      end
    end
  end

  // Stimulus: drive inputs after the falling edge, check state, advance model.
  initial begin
    rst            = 1'b0;
    fetch_en       = 1'b0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    model_reset();
    repeat (2) @(negedge clk);
    #3 rst = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      drive(cyc);
      #2;
      chk("imem_addr", imem_addr, m_pc);
      chk("busy", busy, mode == MFetch);
      chk("fault_misaligned", fault_misaligned, m_fm);
      chk("fault_range", fault_range, m_fr);
      model_step();
      if (cyc == 1499 || cyc == 2400) do_reset();
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
